// File: rtl/adder_share_ctrl.sv
// Round-robin controller sharing one combinational adder among NREQ requesters.
// A registered issue stage drives the adder, and a registered response stage returns each tagged sum.
module adder_share_ctrl #(
  parameter int N    = 30,
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*N-1:0] req_op1,
  input  logic [NREQ*N-1:0] req_op2,
  output logic [NREQ-1:0]   req_ready,
  output logic [N-1:0]      add_in1,
  output logic [N-1:0]      add_in2,
  input  logic [N-1:0]      add_sum,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [N-1:0]      rsp_sum,
  input  logic              rsp_ready,
  output logic [31:0]       op_count
);

  logic            r_iss_vld_p1;
  logic [IDW-1:0]  r_iss_id_p1;
  logic [N-1:0]    r_in1_p1;
  logic [N-1:0]    r_in2_p1;
  logic            r_rsp_vld_p2;
  logic [IDW-1:0]  r_rsp_id_p2;
  logic [N-1:0]    r_rsp_sum_p2;
  logic [IDW-1:0]  r_ptr;
  logic [31:0]     r_op_count;

  logic            w_adv_rsp;
  logic            w_can_acc;
  logic            w_pick_vld;
  logic [IDW-1:0]  w_pick_id;
  logic            w_acc;
  logic [NREQ-1:0] w_grant_oh;
  logic [N-1:0]    w_sel_op1;
  logic [N-1:0]    w_sel_op2;
  logic [IDW-1:0]  w_ptr_nxt;

  // First valid requester at or after ptr; MSB of the result flags a hit.
  function automatic logic [IDW:0] rr_pick(input logic [NREQ-1:0] vld,
                                           input logic [IDW-1:0]  ptr);
    logic [IDW:0]   pick;
    logic [IDW-1:0] idx;
    pick = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IDW'((int'(ptr) + k) % NREQ);
      if (vld[idx]) pick = {1'b1, idx};
    end
    return pick;
  endfunction

  assign w_adv_rsp = r_iss_vld_p1 & (~r_rsp_vld_p2 | rsp_ready);
  assign w_can_acc = ~r_iss_vld_p1 | w_adv_rsp;
  assign {w_pick_vld, w_pick_id} = rr_pick(req_valid, r_ptr);
  assign w_acc     = w_can_acc & w_pick_vld;
  assign w_ptr_nxt = IDW'((int'(w_pick_id) + 1) % NREQ);
  assign w_sel_op1 = req_op1[int'(w_pick_id)*N +: N];
  assign w_sel_op2 = req_op2[int'(w_pick_id)*N +: N];

  always_comb begin
    w_grant_oh = '0;
    if (w_acc) w_grant_oh[w_pick_id] = 1'b1;
  end

  // The grant is suppressed while reset is held, even though the stages read empty.
  assign req_ready = rst ? '0 : w_grant_oh;

  // Issue stage (p1): operands only reload on an accept, so idle cycles cause no adder switching.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_iss_vld_p1 <= 1'b0;
      r_iss_id_p1  <= '0;
      r_in1_p1     <= '0;
      r_in2_p1     <= '0;
    end else if (w_acc) begin
      r_iss_vld_p1 <= 1'b1;
      r_iss_id_p1  <= w_pick_id;
      r_in1_p1     <= w_sel_op1;
      r_in2_p1     <= w_sel_op2;
    end else if (w_adv_rsp) begin
      r_iss_vld_p1 <= 1'b0;
    end
  end

  // Response stage (p2): captures the shared adder's sum, tagged with the issuing requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_vld_p2 <= 1'b0;
      r_rsp_id_p2  <= '0;
      r_rsp_sum_p2 <= '0;
    end else if (w_adv_rsp) begin
      r_rsp_vld_p2 <= 1'b1;
      r_rsp_id_p2  <= r_iss_id_p1;
      r_rsp_sum_p2 <= add_sum;
    end else if (r_rsp_vld_p2 && rsp_ready) begin
      r_rsp_vld_p2 <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr      <= '0;
      r_op_count <= '0;
    end else if (w_acc) begin
      r_ptr      <= w_ptr_nxt;
      r_op_count <= r_op_count + 32'd1;
    end
  end

  assign add_in1   = r_in1_p1;
  assign add_in2   = r_in2_p1;
  assign rsp_valid = r_rsp_vld_p2;
  assign rsp_id    = r_rsp_id_p2;
  assign rsp_sum   = r_rsp_sum_p2;
  assign op_count  = r_op_count;

endmodule

// File: tb/tb_adder_share_ctrl.sv
// Bench for adder_share_ctrl: models the shared adder and scoreboards each tagged response.
module tb_adder_share_ctrl;
  localparam int N    = 30;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*N-1:0] req_op1;
  logic [NREQ*N-1:0] req_op2;
  logic [NREQ-1:0]   req_ready;
  logic [N-1:0]      add_in1;
  logic [N-1:0]      add_in2;
  logic [N-1:0]      add_sum;
  logic              rsp_valid;
  logic [IDW-1:0]    rsp_id;
  logic [N-1:0]      rsp_sum;
  logic              rsp_ready;
  logic [31:0]       op_count;

  logic [N-1:0]      op1_a [NREQ];
  logic [N-1:0]      op2_a [NREQ];
  logic [IDW+N-1:0]  sb [$];
  logic [IDW+N-1:0]  exp_e;
  int                checks    = 0;
  int                failures  = 0;
  int                rsp_seen  = 0;
  int                toggles   = 0;
  logic              tog_en    = 1'b0;

  adder_share_ctrl #(.N(N), .NREQ(NREQ), .IDW(IDW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_op1(req_op1), .req_op2(req_op2),
    .req_ready(req_ready), .add_in1(add_in1), .add_in2(add_in2), .add_sum(add_sum),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
    .op_count(op_count)
  );

  initial forever #5 clk = ~clk;

  // The shared adder itself: modulo 2^N, carry-out dropped.
  assign add_sum = add_in1 + add_in2;

  always_comb begin
    req_op1 = '0;
    req_op2 = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_op1[i*N +: N] = op1_a[i];
      req_op2[i*N +: N] = op2_a[i];
    end
  end

  always @(add_in1 or add_in2) if (tog_en) toggles++;

  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL rsp_unexpected: got id=%0d sum=%h, required no response", rsp_id, rsp_sum);
      end else begin
        exp_e = sb.pop_front();
        rsp_seen++;
        if ({rsp_id, rsp_sum} !== exp_e) begin
          failures++;
          $display("FAIL rsp_data: got id=%0d sum=%h, required id=%0d sum=%h",
                   rsp_id, rsp_sum, exp_e[IDW+N-1:N], exp_e[N-1:0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = '1;
    rsp_ready = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      op1_a[i] = N'($urandom);
      op2_a[i] = N'($urandom);
    end
    #2;
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL reset_req_ready: got %b, required 0", req_ready);
    end
    repeat (2) @(negedge clk);
    checks++;
    if ({add_in1, add_in2} !== '0) begin
      failures++; $display("FAIL reset_add_in: got %h/%h, required 0/0", add_in1, add_in2);
    end
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum} !== '0) begin
      failures++; $display("FAIL reset_rsp: got v=%b id=%0d sum=%h, required all 0", rsp_valid, rsp_id, rsp_sum);
    end
    checks++;
    if (op_count !== 32'd0 || req_ready !== '0) begin
      failures++; $display("FAIL reset_count_ready: got cnt=%0d rdy=%b, required 0/0", op_count, req_ready);
    end
    tick();
    req_valid = '0;
    rst = 1'b0;
  endtask

  task automatic test_single_op();
    op1_a[1] = 30'h0000FFFF;
    op2_a[1] = 30'h3FFF0000;
    req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++; $display("FAIL single_grant: got %b, required 0010", req_ready);
    end
    sb.push_back({2'd1, 30'h3FFFFFFF});
    tick();
    req_valid = '0;
    checks++;
    if (rsp_valid !== 1'b0 || add_in1 !== 30'h0000FFFF) begin
      failures++; $display("FAIL single_issue: got rsp_v=%b in1=%h, required 0/0000ffff", rsp_valid, add_in1);
    end
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd1, 30'h3FFFFFFF}) begin
      failures++; $display("FAIL single_rsp: got v=%b id=%0d sum=%h, required 1/1/3fffffff", rsp_valid, rsp_id, rsp_sum);
    end
    checks++;
    if (op_count !== 32'd1) begin
      failures++; $display("FAIL single_count: got %0d, required 1", op_count);
    end
    tick();
  endtask

  task automatic test_wrap();
    op1_a[3] = 30'h3FFFFFFF;
    op2_a[3] = 30'h00000001;
    req_valid = 4'b1000;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b1000) begin
      failures++; $display("FAIL wrap_grant: got %b, required 1000", req_ready);
    end
    sb.push_back({2'd3, 30'h0});
    tick();
    req_valid = '0;
    tick();
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum} !== {1'b1, 2'd3, 30'h0}) begin
      failures++; $display("FAIL wrap_rsp: got v=%b id=%0d sum=%h, required 1/3/0", rsp_valid, rsp_id, rsp_sum);
    end
    checks++;
    if (op_count !== 32'd2) begin
      failures++; $display("FAIL wrap_count: got %0d, required 2", op_count);
    end
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] exp_rdy;
    int g;
    for (int i = 0; i < NREQ; i++) begin
      op1_a[i] = N'($urandom);
      op2_a[i] = N'($urandom);
    end
    rsp_ready = 1'b1;
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      g = k % NREQ;
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      @(negedge clk);
      checks++;
      if (req_ready !== exp_rdy) begin
        failures++; $display("FAIL rr_grant[%0d]: got %b, required %b", k, req_ready, exp_rdy);
      end
      sb.push_back({IDW'(g), op1_a[g] + op2_a[g]});
      if (k >= 2) begin
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== IDW'((k - 2) % NREQ)) begin
          failures++; $display("FAIL rr_rsp[%0d]: got v=%b id=%0d, required 1/%0d", k, rsp_valid, rsp_id, (k - 2) % NREQ);
        end
      end
      tick();
      op1_a[g] = N'($urandom);
      op2_a[g] = N'($urandom);
    end
    req_valid = '0;
    repeat (3) tick();
    checks++;
    if (op_count !== 32'd10) begin
      failures++; $display("FAIL rr_count: got %0d, required 10", op_count);
    end
  endtask

  task automatic test_backpressure();
    int acc;
    logic [IDW+N-1:0] held;
    acc = 0;
    held = '0;
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    op1_a[0] = N'($urandom);
    op2_a[0] = N'($urandom);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if (k == 2) held = {rsp_id, rsp_sum};
      if (k == 4) begin
        checks++;
        if (rsp_valid !== 1'b1 || {rsp_id, rsp_sum} !== held) begin
          failures++; $display("FAIL bp_stable: got v=%b id/sum=%h, required 1/%h", rsp_valid, {rsp_id, rsp_sum}, held);
        end
      end
      if (req_ready[0]) begin
        acc++;
        sb.push_back({2'd0, op1_a[0] + op2_a[0]});
      end
      tick();
      if (req_ready == '0 && acc > 0 && k < 4) ;
      op1_a[0] = N'($urandom);
      op2_a[0] = N'($urandom);
    end
    checks++;
    if (acc !== 2) begin
      failures++; $display("FAIL bp_accepts: got %0d, required 2", acc);
    end
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL bp_ready_low: got %b, required 0000", req_ready);
    end
    rsp_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (req_ready[0]) begin
        acc++;
        sb.push_back({2'd0, op1_a[0] + op2_a[0]});
      end
      tick();
      op1_a[0] = N'($urandom);
      op2_a[0] = N'($urandom);
    end
    req_valid = '0;
    repeat (4) tick();
    checks++;
    if (acc !== 6 || op_count !== 32'd16) begin
      failures++; $display("FAIL bp_resume: got acc=%0d cnt=%0d, required 6/16", acc, op_count);
    end
    checks++;
    if (sb.size() !== 0 || rsp_seen !== 16) begin
      failures++; $display("FAIL bp_drain: got pending=%0d seen=%0d, required 0/16", sb.size(), rsp_seen);
    end
  endtask

  task automatic test_idle_hold();
    logic [N-1:0] op2_keep;
    op1_a[2] = 30'h12345678;
    op2_a[2] = N'($urandom);
    op2_keep = op2_a[2];
    req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++; $display("FAIL idle_grant: got %b, required 0100", req_ready);
    end
    sb.push_back({2'd2, op1_a[2] + op2_a[2]});
    tick();
    req_valid = '0;
    toggles = 0;
    tog_en = 1'b1;
    for (int k = 0; k < 10; k++) begin
      op1_a[k % NREQ] = N'($urandom);
      op2_a[(k + 1) % NREQ] = N'($urandom);
      tick();
    end
    tog_en = 1'b0;
    checks++;
    if (toggles !== 0) begin
      failures++; $display("FAIL idle_toggles: got %0d, required 0", toggles);
    end
    checks++;
    if (add_in1 !== 30'h12345678 || add_in2 !== op2_keep) begin
      failures++; $display("FAIL idle_hold: got %h/%h, required 12345678/%h", add_in1, add_in2, op2_keep);
    end
  endtask

  task automatic test_reset_mid();
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    op1_a[0] = N'($urandom);
    op2_a[0] = N'($urandom);
    repeat (2) begin
      @(negedge clk);
      if (req_ready[0]) sb.push_back({2'd0, op1_a[0] + op2_a[0]});
      tick();
    end
    checks++;
    if (rsp_valid !== 1'b1) begin
      failures++; $display("FAIL mid_fill: got rsp_v=%b, required 1", rsp_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({rsp_valid, rsp_id, rsp_sum, add_in1, add_in2} !== '0 || op_count !== 32'd0) begin
      failures++; $display("FAIL mid_reset_vals: got v=%b sum=%h in1=%h cnt=%0d, required 0", rsp_valid, rsp_sum, add_in1, op_count);
    end
    checks++;
    if (req_ready !== '0) begin
      failures++; $display("FAIL mid_reset_ready: got %b, required 0000", req_ready);
    end
    sb.delete();
    req_valid = '1;
    for (int i = 0; i < NREQ; i++) begin
      op1_a[i] = N'($urandom);
      op2_a[i] = N'($urandom);
    end
    tick();
    rst = 1'b0;
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++; $display("FAIL mid_first_grant: got %b, required 0001", req_ready);
    end
    sb.push_back({2'd0, op1_a[0] + op2_a[0]});
    tick();
    req_valid = '0;
    repeat (3) tick();
    checks++;
    if (sb.size() !== 0 || op_count !== 32'd1) begin
      failures++; $display("FAIL mid_after: got pending=%0d cnt=%0d, required 0/1", sb.size(), op_count);
    end
  endtask

  initial begin
    test_reset();
    test_single_op();
    test_wrap();
    test_round_robin();
    test_backpressure();
    test_idle_hold();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/adder_share_ctrl.md
# adder_share_ctrl

Round-robin controller that shares one combinational N-bit `adder` among NREQ requesters. It accepts operand pairs over per-requester valid/ready handshakes and drives the adder's `input1`/`input2` from a registered issue stage. It captures `sum` into a registered response stage tagged with the requester ID, and keeps the adder operands frozen while idle so that energy characterization runs see switching only on real operations.

## Interface
- `N`, 30: operand/sum width; must equal the shared adder's width.
- `NREQ`, 4: number of requesters, 2..8.
- `IDW`, 2: requester-ID width; must satisfy 2^IDW >= NREQ.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  NREQ  bit i: requester i presents an operand pair.
- `req_op1`  in  NREQ*N  requester i operand 1 at bits [i*N +: N].
- `req_op2`  in  NREQ*N  requester i operand 2 at bits [i*N +: N].
- `req_ready`  out  NREQ  one-hot or zero; bit i is high when requester i's pair is accepted this cycle.
- `add_in1`  out  N  registered; drives adder `input1`.
- `add_in2`  out  N  registered; drives adder `input2`.
- `add_sum`  in  N  adder `sum`, combinational from `add_in1`/`add_in2`.
- `rsp_valid`  out  1  response stage holds a result.
- `rsp_id`  out  IDW  requester index of the held result.
- `rsp_sum`  out  N  held result.
- `rsp_ready`  in  1  consumer takes the response when high together with `rsp_valid`.
- `op_count`  out  32  number of accepted operations; wraps from 2^32-1 to 0.

## Operation
- State:
  - issue stage: `iss_v`, `iss_id`, `add_in1`, `add_in2`.
  - response stage: `rsp_valid`, `rsp_id`, `rsp_sum`.
  - round-robin pointer `ptr` (0..NREQ-1).
  - `op_count`.
- Advance condition: `adv_rsp = iss_v & (~rsp_valid | rsp_ready)`.
- Accept condition: `can_acc = ~iss_v | adv_rsp`.
- Arbitration:
  - When `can_acc` is high, grant the first i with `req_valid[i]`, searching ptr, ptr+1, ... mod NREQ.
  - `req_ready[i]` = grant; it is combinational from `req_valid`, `ptr` and the stage state, and never depends on `req_op*`.
  - On a grant to g, `ptr` becomes (g+1) mod NREQ. With no grant, `ptr` holds.
- On an accept, the issue stage loads `req_op1`/`req_op2` of g into `add_in1`/`add_in2`, sets `iss_id`=g and `iss_v`=1.
- On `adv_rsp` without an accept, `iss_v` is cleared and `add_in1`/`add_in2` **hold their last values**. They are never zeroed.
- On `adv_rsp`, the response stage loads `rsp_sum`=`add_sum`, `rsp_id`=`iss_id`, `rsp_valid`=1.
- If `rsp_valid & rsp_ready` and there is no `adv_rsp`, `rsp_valid` is cleared; `rsp_sum`/`rsp_id` hold.
- Arithmetic: the sum is modulo 2^N; carry-out is discarded (the adder has no carry port).
- `op_count` increments by 1 on every accept.

## Timing
- Reset values (asynchronous):
  - `iss_v`=0, `add_in1`=0, `add_in2`=0, `iss_id`=0, `ptr`=0.
  - `rsp_valid`=0, `rsp_id`=0, `rsp_sum`=0, `op_count`=0.
  - `req_ready`=0 while `rst` is high.
- Latency: a pair accepted at edge t appears on `rsp_*` after edge t+1 (2 cycles), given no backpressure.
- Throughput: 1 operation per cycle while `rsp_ready`=1.
- Full condition (`iss_v`=1, `rsp_valid`=1, `rsp_ready`=0):
  - no grant;
  - both stages hold;
  - `req_ready`=0.
- Simultaneous events:
  - Response drain, issue advance and new accept can all happen in one cycle.
  - Values are never lost or duplicated.
- Requesters keep `req_valid`/`req_op*` stable until granted. The controller does not check this.
- Reset mid-operation discards in-flight results; no response is emitted for them.

## Test plan
- Single op: requester 1 sends op1=30'h0000FFFF, op2=30'h3FFF0000; `rsp_ready`=1 -> 2 cycles later `rsp_valid`=1, `rsp_id`=1, `rsp_sum`=30'h3FFFFFFF, `op_count`=1.
- Wrap: op1=30'h3FFFFFFF, op2=30'h00000001 -> `rsp_sum`=0.
- Round-robin: all four `req_valid` held high with distinct operands for 8 cycles -> grant order 0,1,2,3,0,1,2,3; responses in the same order, one per cycle.
- Backpressure: `rsp_ready`=0 for 5 cycles with requester 0 streaming -> exactly 2 accepts, then `req_ready`=0. `rsp_*` is stable. Release -> resumes with no loss or duplication.
- Idle hold: after an op with op1=30'h12345678, all `req_valid`=0 for 10 cycles -> `add_in1` stays 30'h12345678, with zero toggles on `add_in*`.
- Reset mid-stream: assert `rst` while both stages are valid -> all outputs go to reset values immediately. After release, the first grant goes to requester 0.
